mem_read_streamer: RTL and testbench
====================================

Name: mem_read_streamer

Overview:
- Read-side sequencer placed directly downstream of the two-port weight/activation buffer memory.
- On a start command it issues a contiguous burst of reads (enb/addrb) to the memory's read port and absorbs the memory's 1-cycle registered read latency.
- It delivers the words as a valid/ready stream to the compute datapath.
- A small credit-controlled skid buffer guarantees no word is lost under consumer backpressure.

Parameters:
- BIT_LENGTH, 64: word width; equals the memory's data width.
- DEPTH, 16: memory depth; address width AW = $clog2(DEPTH).
- SKID_DEPTH, 2: output buffer entries, minimum 2.

Ports:
- clk, input, 1: single clock; the memory read port (clkb) is tied to this clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: one-cycle burst request; sampled only in IDLE.
- base_addr, input, AW: first read address; sampled with start.
- len, input, AW+1: number of words, 0..DEPTH; sampled with start.
- busy, output, 1: high from the cycle after an accepted start until done.
- done, output, 1: one-cycle pulse on burst completion.
- enb, output, 1: memory read enable.
- addrb, output, AW: memory read address.
- doutb, input, BIT_LENGTH: memory read data, valid the cycle after enb.
- m_data, output, BIT_LENGTH: stream data.
- m_valid, output, 1: stream valid.
- m_ready, input, 1: stream ready.

Behaviour:
- Reset values: busy=0, done=0, enb=0, addrb=0, m_valid=0, m_data=0. Skid buffer empties, counters clear, FSM goes to IDLE.
- Reset mid-burst aborts the burst; in-flight read data is discarded and no done pulse is generated.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - start with len>0: latch base_addr into the address counter and len into issue and deliver counters, then go to ISSUE.
  - start with len=0: done=1 the next cycle, no enb, stay IDLE.
  - start while not in IDLE is ignored.
- ISSUE:
  - enb=1 in a cycle only if buf_count + inflight + 1 <= SKID_DEPTH + pop_this_cycle.
    - inflight = enb of the previous cycle.
    - pop_this_cycle = m_valid & m_ready.
  - On each issue: addrb = current address, then address += 1 modulo 2^AW (wraps DEPTH-1 -> 0 for power-of-two DEPTH), issue counter -= 1.
  - Issue counter reaching 0 -> DRAIN.
- Read return: the cycle after enb=1, doutb is written into the skid buffer tail. A push and a pop in the same cycle are legal and leave count unchanged.
- Stream:
  - m_valid = buffer non-empty; m_data = head entry, registered output.
  - Once m_valid is high, m_data must not change until the handshake completes.
  - Words are delivered in address order.
- DRAIN: when the deliver counter reaches 0 (last handshake), pulse done the next cycle, drop busy in that same cycle, and return to IDLE.
- Latency with m_ready held high: start at cycle 0 -> enb at cycle 1 -> first m_valid at cycle 3.
- Sustained throughput is 1 word/cycle when SKID_DEPTH >= 2.
- Overflow is impossible by the credit rule; the bench asserts buf_count <= SKID_DEPTH.

Optional Feature:
- Macro: READ_STREAM_LAST_EN.
- Defined: adds output m_last (1 bit). It is high with m_valid on the final word of the burst only, is reset to 0, and is stored per skid entry.
- Undefined: no m_last port and no extra storage; behaviour is otherwise identical.

Test Plan:
- Basic burst: preload mem[i]=i+100, start base_addr=3 len=4, m_ready=1. Required: enb at cycles 1-4 with addrb 3,4,5,6; m_data 103,104,105,106 on cycles 3-6; done at cycle 7.
- Wrap-around: base_addr=14, len=4, DEPTH=16. Required: addrb sequence 14,15,0,1; data order matches.
- Backpressure: len=8, m_ready toggles 1,0,0,1,... Required:
  - no word lost or duplicated;
  - m_data stable while m_valid & !m_ready;
  - buf_count never exceeds 2;
  - enb held low while credits are exhausted.
- Zero length and ignored start: len=0 gives done one cycle later with no enb. A start pulsed during busy is ignored, and the burst count is unchanged.
- Full memory and reset abort:
  - len=16 from base_addr=0 returns all 16 words in order.
  - Assert rst_n low mid-burst with word 5 pending. Required: all outputs go to reset values immediately, no done pulse, and a new start then operates normally.
- With READ_STREAM_LAST_EN defined: m_last=1 only on the 4th word of a len=4 burst, including under backpressure.

Source files
------------

// File: rtl/mem_read_streamer.sv
// Burst read sequencer: issues contiguous reads to a 1-cycle-latency memory port and
// streams the words out through a credit-controlled skid buffer. Optional macro: READ_STREAM_LAST_EN.
module mem_read_streamer #(
  parameter int BIT_LENGTH = 64,
  parameter int DEPTH      = 16,
  parameter int SKID_DEPTH = 2,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic [AW:0]           len,
  output logic                  busy,
  output logic                  done,
  output logic                  enb,
  output logic [AW-1:0]         addrb,
  input  logic [BIT_LENGTH-1:0] doutb,
  output logic [BIT_LENGTH-1:0] m_data,
  output logic                  m_valid,
`ifdef READ_STREAM_LAST_EN
  input  logic                  m_ready,
  output logic                  m_last
`else
  input  logic                  m_ready
`endif
);

  localparam int LW   = AW + 1;
  localparam int PW   = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CNTW = $clog2(SKID_DEPTH + 1);
  localparam int CRW  = CNTW + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [AW-1:0]   r_addr;
  logic [LW-1:0]   r_issue_cnt;
  logic [LW-1:0]   r_deliver_cnt;
  logic            r_done;
  logic            r_inflight;

  logic [BIT_LENGTH-1:0] r_mem [SKID_DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CNTW-1:0] r_count;

  logic            w_enb;
  logic            w_load;
  logic            w_done_nxt;
  logic            w_pop;
  logic            w_valid;
  logic            w_credit_ok;
  logic [CRW-1:0]  w_need;
  logic [CRW-1:0]  w_avail;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & m_ready;

  // A slot is reserved for the word still in the memory pipeline; a pop in
  // this cycle frees one, which keeps 1 word/cycle with only two entries.
  assign w_need      = CRW'(r_count) + CRW'(r_inflight) + CRW'(1);
  assign w_avail     = CRW'(SKID_DEPTH) + CRW'(w_pop);
  assign w_credit_ok = (w_need <= w_avail);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_enb       = 1'b0;
    w_load      = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            w_load      = 1'b1;
            w_state_nxt = S_ISSUE;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (w_credit_ok) begin
          w_enb = 1'b1;
          if (r_issue_cnt == LW'(1)) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_pop && (r_deliver_cnt == LW'(1))) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr        <= '0;
      r_issue_cnt   <= '0;
      r_deliver_cnt <= '0;
      r_done        <= 1'b0;
      r_inflight    <= 1'b0;
    end else begin
      r_done     <= w_done_nxt;
      r_inflight <= w_enb;
      if (w_load) begin
        r_addr        <= base_addr;
        r_issue_cnt   <= len;
        r_deliver_cnt <= len;
      end else begin
        if (w_enb) begin
          r_addr      <= r_addr + AW'(1);
          r_issue_cnt <= r_issue_cnt - LW'(1);
        end
        if (w_pop && (r_state != S_IDLE)) begin
          r_deliver_cnt <= r_deliver_cnt - LW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (r_inflight) begin
        r_mem[r_tail] <= doutb;
        r_tail        <= ptr_inc(r_tail);
      end
      if (w_pop) begin
        r_head <= ptr_inc(r_head);
      end
      case ({r_inflight, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef READ_STREAM_LAST_EN
  logic r_inflight_last;
  logic r_last_mem [SKID_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight_last <= 1'b0;
      for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
        r_last_mem[i] <= 1'b0;
      end
    end else begin
      r_inflight_last <= w_enb && (r_issue_cnt == LW'(1));
      if (r_inflight) begin
        r_last_mem[r_tail] <= r_inflight_last;
      end
    end
  end

  assign m_last = w_valid & r_last_mem[r_head];
`endif

  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign enb     = w_enb;
  assign addrb   = r_addr;
  assign m_valid = w_valid;
  assign m_data  = r_mem[r_head];

endmodule

// File: tb/tb_mem_read_streamer.sv
// Scoreboard bench for mem_read_streamer: stimulus queues expected addresses/words,
// a negedge monitor pops and compares them as the DUT issues reads and delivers words.
module tb_mem_read_streamer;

  localparam int BL   = 64;
  localparam int DEP  = 16;
  localparam int SKID = 2;
  localparam int AW   = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic          enb;
  logic [AW-1:0] addrb;
  logic [BL-1:0] doutb = '0;
  logic [BL-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
`ifdef READ_STREAM_LAST_EN
  logic          m_last;
`endif

  mem_read_streamer #(.BIT_LENGTH(BL), .DEPTH(DEP), .SKID_DEPTH(SKID)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .enb       (enb),
    .addrb     (addrb),
    .doutb     (doutb),
    .m_data    (m_data),
    .m_valid   (m_valid),
`ifdef READ_STREAM_LAST_EN
    .m_ready   (m_ready),
    .m_last    (m_last)
`else
    .m_ready   (m_ready)
`endif
  );

  always #5 clk = ~clk;

  logic [BL-1:0] mem [DEP];
  always @(posedge clk) if (enb) doutb <= mem[addrb];

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int pop_cnt  = 0;

  logic [AW-1:0] exp_addr [$];
  logic [BL-1:0] exp_data [$];
  bit            exp_last [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(AW'((base + i) % DEP));
      exp_data.push_back(BL'(((base + i) % DEP) + 100));
      exp_last.push_back(i == n - 1);
    end
    base_addr = AW'(base);
    len       = (AW + 1)'(n);
    start     = 1'b1;
    tick;
    start     = 1'b0;
  endtask

  task automatic wait_done(input bit bp, input string name);
    bit seen = 0;
    int ph = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick;
      if (done) seen = 1;
      if (bp) begin
        m_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
        ph++;
      end
    end
    m_ready = 1'b1;
    chk({name, "_done_seen"}, seen, 1);
    chk({name, "_addr_q_empty"}, exp_addr.size(), 0);
    chk({name, "_data_q_empty"}, exp_data.size(), 0);
    tick;
    chk({name, "_done_single"}, done, 0);
    chk({name, "_busy_low"}, busy, 0);
  endtask

  // Monitor: buffer occupancy model, stall stability and in-order scoreboard.
  int            occ = 0;
  bit            enb_p1 = 0, enb_p2 = 0, pop_p1 = 0, hold = 0;
  logic [BL-1:0] hold_data = '0;

  always @(negedge clk) begin
    bit pop;
    if (!rst_n) begin
      occ = 0; enb_p1 = 0; enb_p2 = 0; pop_p1 = 0; hold = 0;
    end else begin
      occ = occ + int'(enb_p2) - int'(pop_p1);
      chk("occ_le_skid", (occ <= SKID), 1);
      chk("valid_vs_occ", m_valid, (occ != 0));
      if (hold) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, hold_data);
      end
      if (enb) begin
        chk("enb_expected", (exp_addr.size() != 0), 1);
        if (exp_addr.size() != 0) chk("addrb", addrb, exp_addr.pop_front());
      end
      pop = m_valid && m_ready;
      if (pop) begin
        pop_cnt++;
        chk("word_expected", (exp_data.size() != 0), 1);
        if (exp_data.size() != 0) begin
`ifdef READ_STREAM_LAST_EN
          chk("m_last", m_last, exp_last[0]);
`endif
          chk("m_data", m_data, exp_data.pop_front());
          void'(exp_last.pop_front());
        end
      end
`ifdef READ_STREAM_LAST_EN
      if (!m_valid) chk("m_last_idle", m_last, 0);
`endif
      if (done) done_cnt++;
      hold      = m_valid && !m_ready;
      hold_data = m_data;
      enb_p2    = enb_p1;
      enb_p1    = enb;
      pop_p1    = pop;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, p0;
    bit reached;
    for (int i = 0; i < DEP; i++) mem[i] = BL'(i + 100);
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b1;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_enb", enb, 0);
    chk("rst_addrb", addrb, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    #10 rst_n = 1'b1;
    tick;

    // Basic burst with exact cycle timing
    issue(3, 4);
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) tick;
      chk($sformatf("basic_enb_c%0d", c), enb, (c <= 4));
      chk($sformatf("basic_valid_c%0d", c), m_valid, (c >= 3 && c <= 6));
      chk($sformatf("basic_done_c%0d", c), done, (c == 7));
      chk($sformatf("basic_busy_c%0d", c), busy, (c <= 6));
    end
    chk("basic_q_empty", exp_data.size(), 0);

    // Address wrap
    issue(14, 4);
    wait_done(0, "wrap");

    // Backpressure
    issue(0, 8);
    wait_done(1, "bp8");
    issue(10, 4);
    wait_done(1, "bp4");

    // Zero length
    d0 = done_cnt;
    issue(7, 0);
    chk("zero_done", done, 1);
    chk("zero_enb", enb, 0);
    chk("zero_busy", busy, 0);
    tick;
    chk("zero_done_single", done, 0);
    chk("zero_done_cnt", done_cnt, d0 + 1);

    // Start while busy is ignored
    d0 = done_cnt;
    issue(2, 3);
    chk("ign_busy", busy, 1);
    base_addr = 4'd9; len = 5'd5; start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(0, "ign");
    tick;
    chk("ign_done_cnt", done_cnt, d0 + 1);
    chk("ign_no_extra_busy", busy, 0);

    // Full memory
    issue(0, 16);
    wait_done(0, "full");

    // Reset abort with word 5 pending
    d0 = done_cnt;
    p0 = pop_cnt;
    issue(0, 16);
    reached = 0;
    for (int i = 0; i < 100 && !reached; i++) begin
      tick;
      if (pop_cnt >= p0 + 5) reached = 1;
    end
    chk("abort_reached_word5", reached, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_enb", enb, 0);
    chk("abort_addrb", addrb, 0);
    chk("abort_m_valid", m_valid, 0);
    chk("abort_m_data", m_data, 0);
    exp_addr.delete();
    exp_data.delete();
    exp_last.delete();
    tick;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick;
    chk("abort_no_done", done_cnt, d0);
    chk("abort_idle", busy, 0);
    issue(5, 3);
    wait_done(0, "post_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
